// File: rtl/weight_buf.sv
// Weight store for the first-layer conv array: pre-loaded while idle, then streamed
// back nine words per 18-cycle slot, wrapping after the last stored kernel.
module weight_buf #(
    parameter int DATA_W = 72,
    parameter int DEPTH  = 576,
    parameter int ADDR_W = 10,
    parameter int GROUP  = 9,
    parameter int SLOT   = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] addr_w,
    input  logic [DATA_W-1:0] data_w,
    input  logic              sta,
    output logic [DATA_W-1:0] weight_o,
    output logic              weight_valid_o,
    output logic [5:0]        group_o,
    output logic              pass_done_o,
    output logic              wr_err_o
);

    localparam int SLOT_W = $clog2(SLOT);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SLOT - 1);
    localparam logic [SLOT_W-1:0] GROUP_LAST = SLOT_W'(GROUP - 1);

    typedef enum logic {IDLE, RUN} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
    logic [5:0]        grpCnt_q, grpCnt_d;
    logic [DATA_W-1:0] weight_q, weight_d;
    logic              valid_q, valid_d;
    logic [5:0]        group_q, group_d;
    logic              passDone_q, passDone_d;
    logic              wrErr_q, wrErr_d;
    logic              memWe;

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        rdAddr_d   = rdAddr_q;
        grpCnt_d   = grpCnt_q;
        weight_d   = weight_q;
        valid_d    = 1'b0;
        group_d    = group_q;
        passDone_d = 1'b0;
        memWe      = write_en && (state_q == IDLE) && (addr_w <= LAST_ADDR);
        wrErr_d    = wrErr_q | (write_en && ((state_q == RUN) || (addr_w > LAST_ADDR)));

        case (state_q)
            IDLE: begin
                if (sta) begin
                    state_d  = RUN;
                    slot_d   = '0;
                    rdAddr_d = '0;
                    grpCnt_d = '0;
                end
            end
            RUN: begin
                if (!sta) begin
                    state_d  = IDLE;
                    slot_d   = '0;
                    rdAddr_d = '0;
                    grpCnt_d = '0;
                end else begin
                    // Slots stay aligned to kernel boundaries, so the group advances on the slot's last issue.
                    if (slot_q <= GROUP_LAST) begin
                        weight_d = mem[rdAddr_q];
                        valid_d  = 1'b1;
                        group_d  = grpCnt_q;
                        if (rdAddr_q == LAST_ADDR) begin
                            rdAddr_d   = '0;
                            passDone_d = 1'b1;
                        end else begin
                            rdAddr_d = rdAddr_q + ADDR_W'(1);
                        end
                        if (slot_q == GROUP_LAST) begin
                            grpCnt_d = (rdAddr_q == LAST_ADDR) ? 6'd0 : grpCnt_q + 6'd1;
                        end
                    end
                    slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            rdAddr_q   <= '0;
            grpCnt_q   <= '0;
            weight_q   <= '0;
            valid_q    <= 1'b0;
            group_q    <= '0;
            passDone_q <= 1'b0;
            wrErr_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            rdAddr_q   <= rdAddr_d;
            grpCnt_q   <= grpCnt_d;
            weight_q   <= weight_d;
            valid_q    <= valid_d;
            group_q    <= group_d;
            passDone_q <= passDone_d;
            wrErr_q    <= wrErr_d;
        end
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[addr_w] <= data_w;
        end
    end

    assign weight_o       = weight_q;
    assign weight_valid_o = valid_q;
    assign group_o        = group_q;
    assign pass_done_o    = passDone_q;
    assign wr_err_o       = wrErr_q;

endmodule

// File: tb/tb_weight_buf.sv
// Scoreboard bench for weight_buf: expected words with their issue cycle are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_weight_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_en;
    logic [9:0]  addr_w;
    logic [71:0] data_w;
    logic        sta;
    logic [71:0] weight_o;
    logic        weight_valid_o;
    logic [5:0]  group_o;
    logic        pass_done_o;
    logic        wr_err_o;

    localparam logic [71:0] NEW0 = 72'h123456789ABCDEF012;

    typedef struct {
        logic [71:0] w;
        logic [5:0]  g;
        logic        p;
        int          c;
    } exp_t;

    exp_t sb[$];
    exp_t monItem;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   n;

    weight_buf dut (
        .clk           (clk),
        .rst           (rst),
        .write_en      (write_en),
        .addr_w        (addr_w),
        .data_w        (data_w),
        .sta           (sta),
        .weight_o      (weight_o),
        .weight_valid_o(weight_valid_o),
        .group_o       (group_o),
        .pass_done_o   (pass_done_o),
        .wr_err_o      (wr_err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [71:0] patWord(input int a);
        logic [7:0] b;
        b = a[7:0];
        return {9{b}};
    endfunction

    task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Word k of pass p, with sta first sampled at the posedge after cycle startN.
    task automatic pushWord(input int k, input int startN, input int p, input logic [71:0] w);
        exp_t e;
        e.w = w;
        e.g = 6'(k / 9);
        e.p = (k == 575);
        e.c = startN + 2 + 1152 * p + 18 * (k / 9) + k % 9;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic we, input logic [9:0] a, input logic [71:0] d);
        write_en = we;
        addr_w   = a;
        data_w   = d;
        @(negedge clk);
        write_en = 1'b0;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, " weight_o"}, weight_o, 72'd0);
        checkOutput({tag, " valid"}, 72'(weight_valid_o), 72'd0);
        checkOutput({tag, " group_o"}, 72'(group_o), 72'd0);
        checkOutput({tag, " pass_done"}, 72'(pass_done_o), 72'd0);
        checkOutput({tag, " wr_err"}, 72'(wr_err_o), 72'd0);
    endtask

    // Monitor: every issued word must match the head of the queue, including its cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (weight_valid_o) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious valid", 72'(weight_valid_o), 72'd0);
                end else begin
                    monItem = sb.pop_front();
                    checkOutput("weight", weight_o, monItem.w);
                    checkOutput("group", 72'(group_o), 72'(monItem.g));
                    checkOutput("pass_done", 72'(pass_done_o), 72'(monItem.p));
                    checkOutput("issue cycle", 72'(cyc), 72'(monItem.c));
                end
            end else begin
                checkOutput("pass_done without valid", 72'(pass_done_o), 72'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, pending=%0d", sb.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; sta = 1'b0; write_en = 1'b0; addr_w = '0; data_w = '0;
        repeat (3) @(negedge clk);
        checkZeroOutputs("reset");
        rst = 1'b0;

        // Mid-cycle reset pulse with no clock edge, then a quiet idle stretch.
        @(negedge clk);
        #2 rst = 1'b1;
        #1 checkZeroOutputs("async reset idle");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("idle valid", 72'(weight_valid_o), 72'd0);

        for (int a = 0; a < 576; a++) applyStimulus(1'b1, 10'(a), patWord(a));
        checkOutput("wr_err after load", 72'(wr_err_o), 72'd0);

        // Full pass with a rejected write during RUN, then the wrap back to word 0.
        n = cyc;
        for (int k = 0; k < 576; k++) pushWord(k, n, 0, patWord(k));
        pushWord(0, n, 1, patWord(0));
        sta = 1'b1;
        waitUntil(n + 4);
        checkOutput("wr_err before run write", 72'(wr_err_o), 72'd0);
        applyStimulus(1'b1, 10'd5, '1);
        checkOutput("wr_err after run write", 72'(wr_err_o), 72'd1);
        waitUntil(n + 2 + 1152);
        sta = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("full pass drained", 72'(sb.size()), 72'd0);
        checkOutput("valid after stop", 72'(weight_valid_o), 72'd0);

        // Abort right after word 20.
        n = cyc;
        for (int k = 0; k <= 20; k++) pushWord(k, n, 0, patWord(k));
        sta = 1'b1;
        waitUntil(n + 2 + 36 + 2);
        sta = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("abort drained", 72'(sb.size()), 72'd0);
        checkOutput("valid after abort", 72'(weight_valid_o), 72'd0);

        // Write on the same edge that samples sta, then reset during slot 4.
        n = cyc;
        pushWord(0, n, 0, NEW0);
        for (int k = 1; k <= 3; k++) pushWord(k, n, 0, patWord(k));
        sta = 1'b1;
        applyStimulus(1'b1, 10'd0, NEW0);
        waitUntil(n + 5);
        #2 rst = 1'b1;
        #1 checkZeroOutputs("async reset run");
        checkOutput("pre-reset drained", 72'(sb.size()), 72'd0);
        @(negedge clk);
        rst = 1'b0;
        n = cyc;
        pushWord(0, n, 0, NEW0);
        for (int k = 1; k <= 2; k++) pushWord(k, n, 0, patWord(k));
        waitUntil(n + 4);
        sta = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("restart drained", 72'(sb.size()), 72'd0);

        // Out-of-range write in IDLE must not alias into the array.
        applyStimulus(1'b1, 10'd600, '1);
        checkOutput("wr_err out of range", 72'(wr_err_o), 72'd1);
        n = cyc;
        pushWord(0, n, 0, NEW0);
        for (int k = 1; k <= 24; k++) pushWord(k, n, 0, patWord(k));
        sta = 1'b1;
        waitUntil(n + 2 + 36 + 6);
        sta = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("final drained", 72'(sb.size()), 72'd0);
        checkOutput("wr_err sticky", 72'(wr_err_o), 72'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
